// File: rtl/alu_design.sv
// Registered ALU with arithmetic and logical command sets. Two-operand commands
// may receive their operands in separate cycles. Multiplies add one cycle of latency.
module alu_design #(
    parameter int N     = 8,
    parameter int CMD_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     opa,
    input  logic [N-1:0]     opb,
    input  logic             cin,
    input  logic             ce,
    input  logic             mode,
    input  logic [CMD_W-1:0] cmd,
    input  logic [1:0]       inp_valid,
    output logic [2*N-1:0]   res,
    output logic             cout,
    output logic             oflow,
    output logic             g,
    output logic             l,
    output logic             e,
    output logic             err
);

    localparam int SH_W = $clog2(N);
    localparam int OUT_W = 2*N + 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_MUL  = 2'd2;

    localparam logic [1:0] SEL_ALU = 2'd0;
    localparam logic [1:0] SEL_ERR = 2'd1;
    localparam logic [1:0] SEL_MUL = 2'd2;

    function automatic logic need_a_f(input logic m, input logic [CMD_W-1:0] c);
        if (m) return (c == 4'd4) || (c == 4'd5);
        else   return (c == 4'd6) || (c == 4'd8) || (c == 4'd9);
    endfunction

    function automatic logic need_b_f(input logic m, input logic [CMD_W-1:0] c);
        if (m) return (c == 4'd6) || (c == 4'd7);
        else   return (c == 4'd7) || (c == 4'd10) || (c == 4'd11);
    endfunction

    function automatic logic two_op_f(input logic m, input logic [CMD_W-1:0] c);
        if (m) return (c <= 4'd3) || ((c >= 4'd8) && (c <= 4'd12));
        else   return (c <= 4'd5) || (c == 4'd12) || (c == 4'd13);
    endfunction

    function automatic logic is_mul_f(input logic m, input logic [CMD_W-1:0] c);
        return m && ((c == 4'd9) || (c == 4'd10));
    endfunction

    logic [1:0]       state_r, state_nxt_s;
    logic [3:0]       cnt_r, cnt_nxt_s;
    logic [N-1:0]     a_r, b_r;
    logic [CMD_W-1:0] cmd_r;
    logic             mode_r, cin_r, wait_b_r;
    logic [2*N-1:0]   mul_res_r;
    logic [OUT_W-1:0] out_r, out_nxt_s;

    logic             latch_s, mul_cap_s, out_ld_s, partner_s, missing_s;
    logic [1:0]       out_sel_s;

    logic             sel_mode_s, sel_cin_s;
    logic [CMD_W-1:0] sel_cmd_s;
    logic [N-1:0]     sel_a_s, sel_b_s;

    logic [2*N-1:0]   alu_res_s;
    logic             alu_cout_s, alu_oflow_s, alu_g_s, alu_l_s, alu_e_s, alu_err_s;
    logic [N:0]       wide_s;
    logic [N-1:0]     narrow_s;
    logic [2*N-1:0]   rot_s;
    logic [SH_W-1:0]  sh_s;
    logic             rot_err_s;

    assign partner_s = wait_b_r ? inp_valid[1] : inp_valid[0];
    assign missing_s = (need_a_f(mode, cmd) && !inp_valid[0]) ||
                       (need_b_f(mode, cmd) && !inp_valid[1]);

    // Operand source: live inputs when idle, latched half plus arriving half while waiting
    always_comb begin
        if (state_r == ST_WAIT) begin
            sel_mode_s = mode_r;
            sel_cmd_s  = cmd_r;
            sel_cin_s  = cin_r;
            sel_a_s    = wait_b_r ? a_r : opa;
            sel_b_s    = wait_b_r ? opb : b_r;
        end else begin
            sel_mode_s = mode;
            sel_cmd_s  = cmd;
            sel_cin_s  = cin;
            sel_a_s    = opa;
            sel_b_s    = opb;
        end
    end

    // Combinational ALU core
    always_comb begin
        alu_res_s   = '0;
        alu_cout_s  = 1'b0;
        alu_oflow_s = 1'b0;
        alu_g_s     = 1'b0;
        alu_l_s     = 1'b0;
        alu_e_s     = 1'b0;
        alu_err_s   = 1'b0;
        wide_s      = '0;
        narrow_s    = '0;
        rot_s       = '0;
        sh_s        = sel_b_s[SH_W-1:0];
        rot_err_s   = (sel_b_s >> SH_W) != '0;
        if (sel_mode_s) begin
            case (sel_cmd_s)
                4'd0: begin
                    wide_s     = {1'b0, sel_a_s} + {1'b0, sel_b_s};
                    alu_res_s  = (2*N)'(wide_s);
                    alu_cout_s = wide_s[N];
                end
                4'd1: begin
                    narrow_s    = sel_a_s - sel_b_s;
                    alu_res_s   = (2*N)'(narrow_s);
                    alu_oflow_s = sel_a_s < sel_b_s;
                end
                4'd2: begin
                    wide_s     = {1'b0, sel_a_s} + {1'b0, sel_b_s} + {{N{1'b0}}, sel_cin_s};
                    alu_res_s  = (2*N)'(wide_s);
                    alu_cout_s = wide_s[N];
                end
                4'd3: begin
                    narrow_s    = sel_a_s - sel_b_s - {{(N-1){1'b0}}, sel_cin_s};
                    alu_res_s   = (2*N)'(narrow_s);
                    alu_oflow_s = {1'b0, sel_a_s} < ({1'b0, sel_b_s} + {{N{1'b0}}, sel_cin_s});
                end
                4'd4: begin
                    wide_s     = {1'b0, sel_a_s} + {{N{1'b0}}, 1'b1};
                    alu_res_s  = (2*N)'(wide_s);
                    alu_cout_s = wide_s[N];
                end
                4'd5: begin
                    narrow_s  = sel_a_s - {{(N-1){1'b0}}, 1'b1};
                    alu_res_s = (2*N)'(narrow_s);
                end
                4'd6: begin
                    wide_s     = {1'b0, sel_b_s} + {{N{1'b0}}, 1'b1};
                    alu_res_s  = (2*N)'(wide_s);
                    alu_cout_s = wide_s[N];
                end
                4'd7: begin
                    narrow_s  = sel_b_s - {{(N-1){1'b0}}, 1'b1};
                    alu_res_s = (2*N)'(narrow_s);
                end
                4'd8: begin
                    alu_g_s = sel_a_s > sel_b_s;
                    alu_l_s = sel_a_s < sel_b_s;
                    alu_e_s = sel_a_s == sel_b_s;
                end
                4'd9: alu_res_s = ((2*N)'(sel_a_s) + (2*N)'(1'b1)) * ((2*N)'(sel_b_s) + (2*N)'(1'b1));
                4'd10: alu_res_s = (2*N)'({sel_a_s, 1'b0}) * (2*N)'(sel_b_s);
                4'd11: begin
                    narrow_s    = sel_a_s + sel_b_s;
                    alu_res_s   = (2*N)'(narrow_s);
                    alu_oflow_s = (sel_a_s[N-1] == sel_b_s[N-1]) && (narrow_s[N-1] != sel_a_s[N-1]);
                    alu_g_s     = $signed(sel_a_s) > $signed(sel_b_s);
                    alu_l_s     = $signed(sel_a_s) < $signed(sel_b_s);
                    alu_e_s     = sel_a_s == sel_b_s;
                end
                4'd12: begin
                    narrow_s    = sel_a_s - sel_b_s;
                    alu_res_s   = (2*N)'(narrow_s);
                    alu_oflow_s = (sel_a_s[N-1] != sel_b_s[N-1]) && (narrow_s[N-1] != sel_a_s[N-1]);
                    alu_g_s     = $signed(sel_a_s) > $signed(sel_b_s);
                    alu_l_s     = $signed(sel_a_s) < $signed(sel_b_s);
                    alu_e_s     = sel_a_s == sel_b_s;
                end
                default: alu_err_s = 1'b1;
            endcase
        end else begin
            case (sel_cmd_s)
                4'd0:  narrow_s = sel_a_s & sel_b_s;
                4'd1:  narrow_s = ~(sel_a_s & sel_b_s);
                4'd2:  narrow_s = sel_a_s | sel_b_s;
                4'd3:  narrow_s = ~(sel_a_s | sel_b_s);
                4'd4:  narrow_s = sel_a_s ^ sel_b_s;
                4'd5:  narrow_s = ~(sel_a_s ^ sel_b_s);
                4'd6:  narrow_s = ~sel_a_s;
                4'd7:  narrow_s = ~sel_b_s;
                4'd8:  narrow_s = sel_a_s >> 1'b1;
                4'd9:  narrow_s = sel_a_s << 1'b1;
                4'd10: narrow_s = sel_b_s >> 1'b1;
                4'd11: narrow_s = sel_b_s << 1'b1;
                4'd12: begin
                    rot_s     = {sel_a_s, sel_a_s} << sh_s;
                    narrow_s  = rot_s[2*N-1:N];
                    alu_err_s = rot_err_s;
                end
                4'd13: begin
                    rot_s     = {sel_a_s, sel_a_s} >> sh_s;
                    narrow_s  = rot_s[N-1:0];
                    alu_err_s = rot_err_s;
                end
                default: alu_err_s = 1'b1;
            endcase
            alu_res_s = (2*N)'(narrow_s);
        end
    end

    // Sequencing: idle issue, split-operand wait with 16-cycle window, multiply delay
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        latch_s     = 1'b0;
        mul_cap_s   = 1'b0;
        out_ld_s    = 1'b0;
        out_sel_s   = SEL_ALU;
        case (state_r)
            ST_IDLE: begin
                if (inp_valid == 2'b00) begin
                    state_nxt_s = ST_IDLE;
                end else if (two_op_f(mode, cmd) && (inp_valid != 2'b11)) begin
                    latch_s     = 1'b1;
                    cnt_nxt_s   = 4'd1;
                    state_nxt_s = ST_WAIT;
                end else if (missing_s) begin
                    out_ld_s  = 1'b1;
                    out_sel_s = SEL_ERR;
                end else if (is_mul_f(mode, cmd)) begin
                    mul_cap_s   = 1'b1;
                    state_nxt_s = ST_MUL;
                end else begin
                    out_ld_s = 1'b1;
                end
            end
            ST_WAIT: begin
                if (partner_s) begin
                    if (is_mul_f(mode_r, cmd_r)) begin
                        mul_cap_s   = 1'b1;
                        state_nxt_s = ST_MUL;
                    end else begin
                        out_ld_s    = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                end else if (cnt_r == 4'd15) begin
                    out_ld_s    = 1'b1;
                    out_sel_s   = SEL_ERR;
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s = cnt_r + 4'd1;
                end
            end
            ST_MUL: begin
                out_ld_s    = 1'b1;
                out_sel_s   = SEL_MUL;
                state_nxt_s = ST_IDLE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next output word {res, cout, oflow, g, l, e, err}
    always_comb begin
        case (out_sel_s)
            SEL_ALU: out_nxt_s = {alu_res_s, alu_cout_s, alu_oflow_s, alu_g_s, alu_l_s, alu_e_s, alu_err_s};
            SEL_ERR: out_nxt_s = {{(2*N){1'b0}}, 6'b000001};
            SEL_MUL: out_nxt_s = {mul_res_r, 6'b000000};
            default: out_nxt_s = '0;
        endcase
    end

    // State, operand latches and output register; ce=0 freezes everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            a_r       <= '0;
            b_r       <= '0;
            cmd_r     <= '0;
            mode_r    <= 1'b0;
            cin_r     <= 1'b0;
            wait_b_r  <= 1'b0;
            mul_res_r <= '0;
            out_r     <= '0;
        end else if (ce) begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (latch_s) begin
                a_r      <= opa;
                b_r      <= opb;
                cmd_r    <= cmd;
                mode_r   <= mode;
                cin_r    <= cin;
                wait_b_r <= inp_valid[0];
            end
            if (mul_cap_s) begin
                mul_res_r <= alu_res_s;
            end
            if (out_ld_s) begin
                out_r <= out_nxt_s;
            end
        end
    end

    assign {res, cout, oflow, g, l, e, err} = out_r;

endmodule

// File: tb/tb_alu_design.sv
// Directed, table-driven bench for alu_design with hand sequences for
// split operands, timeout, clock enable and asynchronous reset.
module tb_alu_design;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  opa, opb;
    logic        cin, ce, mode;
    logic [3:0]  cmd;
    logic [1:0]  inp_valid;
    logic [15:0] res;
    logic        cout, oflow, g, l, e, err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic       m;
        logic [3:0] c;
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [15:0] r;
        logic [5:0] f;    // {cout, oflow, g, l, e, err}
        int         lat;
    } vec_t;

    vec_t vq[$];
    logic [21:0] prev;

    alu_design #(.N(8), .CMD_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opa(opa), .opb(opb), .cin(cin), .ce(ce),
        .mode(mode), .cmd(cmd), .inp_valid(inp_valid),
        .res(res), .cout(cout), .oflow(oflow), .g(g), .l(l), .e(e), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] obs();
        return {res, cout, oflow, g, l, e, err};
    endfunction

    task automatic chk(input string nm, input logic [21:0] exp);
        logic [21:0] act;
        act = obs();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got res=%h flags=%b, expected res=%h flags=%b",
                     nm, act[21:6], act[5:0], exp[21:6], exp[5:0]);
        end
    endtask

    task automatic add(input string nm, input logic m, input logic [3:0] c, input logic [7:0] a,
                       input logic [7:0] b, input logic ci, input logic [15:0] r,
                       input logic [5:0] f, input int lat);
        vec_t v;
        v.name = nm; v.m = m; v.c = c; v.a = a; v.b = b; v.ci = ci;
        v.r = r; v.f = f; v.lat = lat;
        vq.push_back(v);
    endtask

    task automatic drive(input logic m, input logic [3:0] c, input logic [7:0] a,
                         input logic [7:0] b, input logic ci, input logic [1:0] v);
        mode = m; cmd = c; opa = a; opb = b; cin = ci; inp_valid = v;
    endtask

    initial begin
        //  name         m  cmd    a      b     cin  res        {co,of,g,l,e,er} lat
        add("add_ff01",  1, 4'd0,  8'hFF, 8'h01, 0, 16'h0100, 6'b100000, 1);
        add("add_plain", 1, 4'd0,  8'h10, 8'h20, 0, 16'h0030, 6'b000000, 1);
        add("sub",       1, 4'd1,  8'h09, 8'h05, 0, 16'h0004, 6'b000000, 1);
        add("sub_brw",   1, 4'd1,  8'h03, 8'h05, 0, 16'h00FE, 6'b010000, 1);
        add("add_cin",   1, 4'd2,  8'hFF, 8'h00, 1, 16'h0100, 6'b100000, 1);
        add("sub_cin",   1, 4'd3,  8'h05, 8'h05, 1, 16'h00FF, 6'b010000, 1);
        add("inc_a",     1, 4'd4,  8'hFF, 8'h00, 0, 16'h0100, 6'b100000, 1);
        add("dec_a",     1, 4'd5,  8'h00, 8'h00, 0, 16'h00FF, 6'b000000, 1);
        add("inc_b",     1, 4'd6,  8'h00, 8'h07, 0, 16'h0008, 6'b000000, 1);
        add("dec_b",     1, 4'd7,  8'h00, 8'h07, 0, 16'h0006, 6'b000000, 1);
        add("cmp_lt",    1, 4'd8,  8'h05, 8'h09, 0, 16'h0000, 6'b000100, 1);
        add("cmp_eq",    1, 4'd8,  8'h07, 8'h07, 0, 16'h0000, 6'b000010, 1);
        add("cmp_gt",    1, 4'd8,  8'h09, 8'h05, 0, 16'h0000, 6'b001000, 1);
        add("mul_inc",   1, 4'd9,  8'h03, 8'h04, 0, 16'd20,   6'b000000, 2);
        add("mul_incmx", 1, 4'd9,  8'hFF, 8'hFF, 0, 16'h0000, 6'b000000, 2);
        add("mul_shl",   1, 4'd10, 8'h03, 8'h04, 0, 16'd24,   6'b000000, 2);
        add("mul_shlmx", 1, 4'd10, 8'hFF, 8'hFF, 0, 16'hFC02, 6'b000000, 2);
        add("sadd_ovf",  1, 4'd11, 8'h7F, 8'h01, 0, 16'h0080, 6'b011000, 1);
        add("sadd_neg",  1, 4'd11, 8'hFF, 8'h01, 0, 16'h0000, 6'b000100, 1);
        add("ssub_ovf",  1, 4'd12, 8'h80, 8'h01, 0, 16'h007F, 6'b010100, 1);
        add("ssub_eq",   1, 4'd12, 8'h05, 8'h05, 0, 16'h0000, 6'b000010, 1);
        add("arith_bad", 1, 4'd13, 8'h05, 8'h05, 0, 16'h0000, 6'b000001, 1);
        add("and",       0, 4'd0,  8'hF0, 8'h3C, 0, 16'h0030, 6'b000000, 1);
        add("nand",      0, 4'd1,  8'hF0, 8'h3C, 0, 16'h00CF, 6'b000000, 1);
        add("or",        0, 4'd2,  8'hF0, 8'h3C, 0, 16'h00FC, 6'b000000, 1);
        add("nor",       0, 4'd3,  8'hF0, 8'h3C, 0, 16'h0003, 6'b000000, 1);
        add("xor",       0, 4'd4,  8'hF0, 8'h3C, 0, 16'h00CC, 6'b000000, 1);
        add("xnor",      0, 4'd5,  8'hF0, 8'h3C, 0, 16'h0033, 6'b000000, 1);
        add("not_a",     0, 4'd6,  8'hF0, 8'h3C, 0, 16'h000F, 6'b000000, 1);
        add("not_b",     0, 4'd7,  8'hF0, 8'h3C, 0, 16'h00C3, 6'b000000, 1);
        add("shr_a",     0, 4'd8,  8'h81, 8'h3C, 0, 16'h0040, 6'b000000, 1);
        add("shl_a",     0, 4'd9,  8'h81, 8'h3C, 0, 16'h0002, 6'b000000, 1);
        add("shr_b",     0, 4'd10, 8'h81, 8'h3C, 0, 16'h001E, 6'b000000, 1);
        add("shl_b",     0, 4'd11, 8'h81, 8'h3C, 0, 16'h0078, 6'b000000, 1);
        add("rol1",      0, 4'd12, 8'h81, 8'h01, 0, 16'h0003, 6'b000000, 1);
        add("rol_err",   0, 4'd12, 8'h81, 8'h11, 0, 16'h0003, 6'b000001, 1);
        add("ror1",      0, 4'd13, 8'h81, 8'h01, 0, 16'h00C0, 6'b000000, 1);
        add("ror7",      0, 4'd13, 8'h01, 8'h07, 0, 16'h0002, 6'b000000, 1);
        add("logic_bad", 0, 4'd14, 8'h01, 8'h07, 0, 16'h0000, 6'b000001, 1);

        rst_n = 1'b0; ce = 1'b1;
        drive(0, 4'd0, 8'h00, 8'h00, 0, 2'b00);
        #12;
        chk("reset", 22'h0);
        @(negedge clk) rst_n = 1'b1;
        prev = 22'h0;

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].m, vq[i].c, vq[i].a, vq[i].b, vq[i].ci, 2'b11);
            @(posedge clk); #1;
            if (vq[i].lat == 2) begin
                chk({vq[i].name, "_hold"}, prev);
                @(posedge clk); #1;
            end
            chk(vq[i].name, {vq[i].r, vq[i].f});
            prev = {vq[i].r, vq[i].f};
        end

        // Split operands: A on cycle 1, B on cycle 6; cmd change meanwhile ignored
        @(negedge clk) drive(1, 4'd0, 8'd10, 8'd0, 0, 2'b01);
        @(posedge clk);
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk) drive(1, 4'd1, 8'd99, 8'd0, 0, 2'b00);
            @(posedge clk);
        end
        #1 chk("split_hold", prev);
        @(negedge clk) drive(1, 4'd1, 8'd0, 8'd5, 0, 2'b10);
        @(posedge clk); #1;
        chk("split_add", {16'd15, 6'b000000});

        // Partner arriving on the 16th cycle is still accepted
        @(negedge clk) drive(1, 4'd0, 8'd1, 8'd0, 0, 2'b01);
        @(posedge clk);
        for (int k = 2; k <= 15; k++) begin
            @(negedge clk) drive(1, 4'd0, 8'd0, 8'd0, 0, 2'b00);
            @(posedge clk);
        end
        @(negedge clk) drive(1, 4'd0, 8'd0, 8'd2, 0, 2'b10);
        @(posedge clk); #1;
        chk("split_16th", {16'd3, 6'b000000});

        // No partner within 16 cycles -> error
        @(negedge clk) drive(1, 4'd0, 8'd1, 8'd0, 0, 2'b01);
        @(posedge clk);
        for (int k = 2; k <= 15; k++) begin
            @(negedge clk) drive(1, 4'd0, 8'd0, 8'd0, 0, 2'b00);
            @(posedge clk);
        end
        #1 chk("timeout_pre", {16'd3, 6'b000000});
        @(posedge clk); #1;
        chk("timeout", {16'd0, 6'b000001});

        // Single-operand command missing its operand
        @(negedge clk) drive(1, 4'd0, 8'd7, 8'd7, 0, 2'b11);
        @(posedge clk); #1;
        chk("pre_missing", {16'd14, 6'b000000});
        @(negedge clk) drive(1, 4'd4, 8'd5, 8'd0, 0, 2'b10);
        @(posedge clk); #1;
        chk("missing_a", {16'd0, 6'b000001});

        // inp_valid=00 holds outputs
        @(negedge clk) drive(1, 4'd0, 8'd1, 8'd1, 0, 2'b00);
        @(posedge clk); #1;
        chk("valid00_hold", {16'd0, 6'b000001});

        // ce=0 holds, then resumes
        @(negedge clk) begin drive(1, 4'd0, 8'd1, 8'd1, 0, 2'b11); ce = 1'b0; end
        repeat (3) @(posedge clk);
        #1 chk("ce_hold", {16'd0, 6'b000001});
        @(negedge clk) ce = 1'b1;
        @(posedge clk); #1;
        chk("ce_resume", {16'd2, 6'b000000});

        // Asynchronous reset in the middle of a multiply
        @(negedge clk) drive(1, 4'd9, 8'd3, 8'd4, 0, 2'b11);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1 chk("reset_mid_mul", 22'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_mul_cancel", 22'h0);
        @(posedge clk); #1;
        chk("mul_after_reset", {16'd20, 6'b000000});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
